mips_fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB.
- Generates the registered ALU operand-select codes `fa`/`fb` that steer the EX-stage operand muxes.
- Detects load-use hazards; asserts `stall` to hold PC/IFID and `bubble` to zero IDEX.

---
 rtl/mips_fwd_hazard_ctrl.sv | 94 +++++++++
 tb/tb_mips_fwd_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mips_fwd_hazard_ctrl.sv
// mips_fwd_hazard_ctrl: registered EX operand forwarding and load-use stall control for a 5-stage MIPS pipeline.
// Define MIPS_STALL_CNT_EN to add the saturating stall_cnt output.
module mips_fwd_hazard_ctrl #(
    parameter logic [5:0] ALUOP   = 6'd0,
    parameter logic [5:0] LW      = 6'd35,
    parameter logic [5:0] SW      = 6'd43,
    parameter logic [5:0] ADD_IMM = 6'd8,
    parameter logic [5:0] JOP     = 6'd2,
    parameter logic [5:0] JALOP   = 6'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] id_ir,
    input  logic        freeze,
    output logic [1:0]  fa,
    output logic [1:0]  fb,
    output logic        stall,
    output logic        bubble,
    output logic        hazard_state
`ifdef MIPS_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;
    state_t state;
    logic [5:0] op;
    logic [4:0] rs, rt, rd, dest;
    logic use_rs, use_rt, is_load, hazard;
    logic [1:0] fa_n, fb_n;
    logic ex_v, mem_v, wb_v, ex_l, mem_l, wb_l;
    logic [4:0] ex_d, mem_d, wb_d;
    logic unused_bits;

    assign op = id_ir[31:26];
    assign rs = id_ir[25:21];
    assign rt = id_ir[20:16];
    assign rd = id_ir[15:11];
    assign hazard_state = state;
    // WB entry and its load flag are tracked for completeness but not consulted.
    assign unused_bits = ^{id_ir[10:0], wb_v, wb_d, wb_l, mem_l, JOP};

    always_comb begin
        dest    = op == ALUOP ? rd : (op == LW || op == ADD_IMM) ? rt : op == JALOP ? 5'd31 : 5'd0;
        use_rs  = op == ALUOP || op == SW || op == LW || op == ADD_IMM;
        use_rt  = op == ALUOP || op == SW;
        is_load = op == LW;
        hazard  = !freeze && state == RUN && ex_v && ex_l &&
                  ((use_rs && rs == ex_d) || (use_rt && rt == ex_d));
        stall   = freeze || hazard;
        bubble  = hazard;
        fa_n    = !use_rs ? 2'b00 : (ex_v && rs == ex_d) ? 2'b10 : (mem_v && rs == mem_d) ? 2'b01 : 2'b00;
        fb_n    = !use_rt ? 2'b00 : (ex_v && rt == ex_d) ? 2'b10 : (mem_v && rt == mem_d) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_v  <= 1'b0;
            mem_v <= 1'b0;
            wb_v  <= 1'b0;
            ex_d  <= 5'd0;
            mem_d <= 5'd0;
            wb_d  <= 5'd0;
            ex_l  <= 1'b0;
            mem_l <= 1'b0;
            wb_l  <= 1'b0;
            fa    <= 2'b00;
            fb    <= 2'b00;
            state <= RUN;
        end else if (!freeze) begin
            wb_v  <= mem_v;
            wb_d  <= mem_d;
            wb_l  <= mem_l;
            mem_v <= ex_v;
            mem_d <= ex_d;
            mem_l <= ex_l;
            ex_v  <= !bubble && dest != 5'd0;
            ex_d  <= dest;
            ex_l  <= is_load;
            fa    <= bubble ? 2'b00 : fa_n;
            fb    <= bubble ? 2'b00 : fb_n;
            state <= bubble ? LSTALL : RUN;
        end
    end

`ifdef MIPS_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt <= 16'd0;
        else if (!freeze && bubble && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mips_fwd_hazard_ctrl.sv
// tb_mips_fwd_hazard_ctrl: scoreboard bench; a pipeline-occupancy model predicts outputs, a monitor checks them.
module tb_mips_fwd_hazard_ctrl;
    logic clk = 0, reset = 1, freeze = 0;
    logic [31:0] id_ir = 32'h0;
    logic [1:0] fa, fb;
    logic stall, bubble, hazard_state;
    logic [15:0] cnt_out;
    int total = 0, bad = 0;
    bit rand_frz = 0;

    typedef struct {
        logic [1:0] fa, fb;
        logic stall, bubble, st;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    int pd[3];
    bit pl[3];
    logic [1:0] m_fa, m_fb;
    bit m_lst;
    int m_cnt;

    always #5 clk = ~clk;

    mips_fwd_hazard_ctrl dut (
        .clock(clk), .reset(reset), .id_ir(id_ir), .freeze(freeze),
        .fa(fa), .fb(fb), .stall(stall), .bubble(bubble), .hazard_state(hazard_state)
`ifdef MIPS_STALL_CNT_EN
        , .stall_cnt(cnt_out)
`endif
    );
`ifndef MIPS_STALL_CNT_EN
    assign cnt_out = 16'd0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] rty(input int rd, input int rs, input int rt);
        logic [4:0] a = 5'(rs), b = 5'(rt), c = 5'(rd);
        return {6'd0, a, b, c, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] ity(input logic [5:0] op, input int rt, input int rs, input int imm);
        logic [4:0] a = 5'(rs), b = 5'(rt);
        return {op, a, b, 16'(imm)};
    endfunction

    // Which register the instruction writes (0 = none) and which it reads.
    function automatic void decode(input logic [31:0] ir, output int d, output bit urs, output bit urt);
        int op = int'(ir[31:26]);
        d = op == 0 ? int'(ir[15:11]) : (op == 35 || op == 8) ? int'(ir[20:16]) : op == 3 ? 31 : 0;
        urs = op == 0 || op == 43 || op == 35 || op == 8;
        urt = op == 0 || op == 43;
    endfunction

    function automatic logic [1:0] fwd(input bit used, input int r);
        if (!used || r == 0) return 2'b00;
        if (pd[0] == r) return 2'b10;
        if (pd[1] == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input logic [31:0] ir, input bit frz, input bit rst, output bit stl);
        int d, rs, rt;
        bit urs, urt, haz;
        exp_t e;
        @(negedge clk);
        id_ir = ir;
        freeze = frz;
        reset = rst;
        decode(ir, d, urs, urt);
        rs = int'(ir[25:21]);
        rt = int'(ir[20:16]);
        haz = !frz && pd[0] != 0 && pl[0] && ((urs && rs == pd[0]) || (urt && rt == pd[0]));
        e.fa = m_fa; e.fb = m_fb; e.st = m_lst; e.cnt = m_cnt;
        e.stall = frz || haz; e.bubble = haz;
        exp_q.push_back(e);
        stl = e.stall;
        if (rst) begin
            pd = '{0, 0, 0}; pl = '{0, 0, 0};
            m_fa = 0; m_fb = 0; m_lst = 0; m_cnt = 0;
        end else if (!frz) begin
            m_fa = haz ? 2'b00 : fwd(urs, rs);
            m_fb = haz ? 2'b00 : fwd(urt, rt);
            pd[2] = pd[1]; pl[2] = pl[1];
            pd[1] = pd[0]; pl[1] = pl[0];
            pd[0] = haz ? 0 : d; pl[0] = !haz && ir[31:26] == 6'd35;
            m_lst = haz;
            if (haz && m_cnt < 65535) m_cnt++;
        end
    endtask

    // Present ir until the pipeline accepts it (stall held IFID).
    task automatic issue(input logic [31:0] ir);
        bit s;
        do step(ir, rand_frz && $urandom_range(0, 6) == 0, 0, s); while (s);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fa", 16'(fa), 16'(e.fa));
                chk("fb", 16'(fb), 16'(e.fb));
                chk("stall", 16'(stall), 16'(e.stall));
                chk("bubble", 16'(bubble), 16'(e.bubble));
                chk("state", 16'(hazard_state), 16'(e.st));
`ifdef MIPS_STALL_CNT_EN
                chk("stall_cnt", cnt_out, 16'(e.cnt));
`endif
            end
        end
    end

    initial begin
        bit s;
        logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd2, 6'd3, 6'd4};
        logic [31:0] ir;
        repeat (2) @(negedge clk);
        pd = '{0, 0, 0}; pl = '{0, 0, 0};
        m_fa = 0; m_fb = 0; m_lst = 0; m_cnt = 0;
        step(32'h0, 0, 1, s);
        repeat (4) issue(32'h0);
        issue(rty(3, 1, 2)); issue(rty(4, 3, 3)); issue(32'h0); issue(32'h0);
        issue(rty(3, 1, 2)); issue(32'h0); issue(rty(5, 3, 1)); issue(32'h0); issue(32'h0);
        issue(ity(6'd35, 6, 1, 0)); issue(rty(7, 6, 2)); issue(32'h0); issue(32'h0);
        issue(rty(0, 1, 2)); issue(rty(8, 0, 0)); issue(32'h0);
        issue(ity(6'd8, 9, 1, 4)); issue(ity(6'd8, 9, 9, 1)); issue(rty(10, 9, 9)); issue(32'h0);
        issue(ity(6'd35, 6, 1, 0));
        repeat (3) step(rty(7, 6, 2), 1, 0, s);
        issue(rty(7, 6, 2)); issue(32'h0);
        issue(ity(6'd35, 6, 1, 0)); issue(ity(6'd35, 7, 1, 4)); issue(rty(8, 6, 7)); issue(32'h0);
        issue(ity(6'd35, 6, 1, 0));
        step(rty(7, 6, 2), 0, 0, s);
        step(rty(7, 6, 2), 0, 1, s);
        step(32'h0, 0, 0, s);
        step(32'h0, 0, 0, s);
        rand_frz = 1;
        for (int i = 0; i < 400; i++) begin
            ir = $urandom;
            ir[31:26] = ops[$urandom_range(0, 6)];
            ir[25:21] = 5'($urandom_range(0, 4));
            ir[20:16] = 5'($urandom_range(0, 4));
            ir[15:11] = 5'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) step(ir, 0, 1, s);
            else issue(ir);
        end
        repeat (3) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
